// File: rtl/hazard_scoreboard_unit.sv
// hazard_scoreboard_unit
//   Hazard unit for the scalar+vector F/D/E/M/W pipeline: M/W operand forwarding,
//   per-register load scoreboard for multi-cycle loads, and branch/PC-write
//   stall and flush control.
//   Optional feature: define HAZARD_PERF_EN to add the StallCnt/FlushCnt
//   performance counters.
module hazard_scoreboard_unit #(
    parameter  int NREG   = 16,
    parameter  int NVREG  = 16,
    parameter  int LD_LAT = 2,
    parameter  int PC_REG = 15,
    localparam int AW     = $clog2(NREG),
    localparam int VW     = $clog2(NVREG)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] RA1D,
    input  logic [AW-1:0] RA2D,
    input  logic [VW-1:0] RA1VD,
    input  logic [VW-1:0] RA2VD,
    input  logic [AW-1:0] RA1E,
    input  logic [AW-1:0] RA2E,
    input  logic [VW-1:0] RA1VE,
    input  logic [VW-1:0] RA2VE,
    input  logic [AW-1:0] WA3E,
    input  logic [AW-1:0] WA3M,
    input  logic [AW-1:0] WA3W,
    input  logic          RegWriteM,
    input  logic          RegWriteW,
    input  logic          RegWriteVM,
    input  logic          RegWriteVW,
    input  logic          MemtoRegE,
    input  logic          VLoadE,
    input  logic          PCSrcD,
    input  logic          PCSrcE,
    input  logic          PCSrcM,
    input  logic          PCSrcW,
    input  logic          BranchTakenE,
    output logic [1:0]    ForwardAE,
    output logic [1:0]    ForwardBE,
    output logic [1:0]    ForwardAVE,
    output logic [1:0]    ForwardBVE,
    output logic          StallF,
    output logic          StallD,
    output logic          FlushE,
    output logic          FlushD
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]   StallCnt,
    output logic [31:0]   FlushCnt
`endif
);

    localparam int            CW        = $clog2(LD_LAT + 1);
    localparam logic [CW-1:0] LOAD_INIT = CW'(LD_LAT - 1);
    localparam logic [AW-1:0] PC_IDX    = AW'(PC_REG);
    // With LD_LAT=1 the result is forwardable from W without any extra wait.
    localparam bit            SB_EN     = (LD_LAT > 1);

    // Remaining busy cycles per destination register after the load leaves E.
    logic [CW-1:0] sbS [NREG];
    logic [CW-1:0] sbV [NVREG];

    logic          setS;
    logic          setV;
    logic [1:0]    fwdA;
    logic [1:0]    fwdB;
    logic [1:0]    fwdAV;
    logic [1:0]    fwdBV;
    logic          ldStallE;
    logic          sbStall;
    logic          ldStall;
    logic          pcWrPend;

    // A squashed load (BranchTakenE) never reserves its destination.
    assign setS = SB_EN & MemtoRegE & ~BranchTakenE & (WA3E != PC_IDX);
    assign setV = SB_EN & VLoadE & ~BranchTakenE;

    // Scalar scoreboard: reload wins over the per-cycle decrement, zero holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                sbS[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NREG; i++) begin
                if (setS && (WA3E == AW'(i))) begin
                    sbS[i] <= LOAD_INIT;
                end else if (sbS[i] != '0) begin
                    sbS[i] <= sbS[i] - CW'(1);
                end
            end
        end
    end

    // Vector scoreboard: same policy, indexed by the low VW bits of WA3E.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NVREG; i++) begin
                sbV[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NVREG; i++) begin
                if (setV && (WA3E[VW-1:0] == VW'(i))) begin
                    sbV[i] <= LOAD_INIT;
                end else if (sbV[i] != '0) begin
                    sbV[i] <= sbV[i] - CW'(1);
                end
            end
        end
    end

    // Scalar forwarding select: M beats W, the PC index always reads the regfile path.
    always_comb begin
        fwdA = 2'b00;
        fwdB = 2'b00;
        if (RA1E != PC_IDX) begin
            if (RegWriteM && (RA1E == WA3M)) begin
                fwdA = 2'b10;
            end else if (RegWriteW && (RA1E == WA3W)) begin
                fwdA = 2'b01;
            end
        end
        if (RA2E != PC_IDX) begin
            if (RegWriteM && (RA2E == WA3M)) begin
                fwdB = 2'b10;
            end else if (RegWriteW && (RA2E == WA3W)) begin
                fwdB = 2'b01;
            end
        end
    end

    // Vector forwarding select: M beats W, destination taken from the low VW bits.
    always_comb begin
        fwdAV = 2'b00;
        fwdBV = 2'b00;
        if (RegWriteVM && (RA1VE == WA3M[VW-1:0])) begin
            fwdAV = 2'b10;
        end else if (RegWriteVW && (RA1VE == WA3W[VW-1:0])) begin
            fwdAV = 2'b01;
        end
        if (RegWriteVM && (RA2VE == WA3M[VW-1:0])) begin
            fwdBV = 2'b10;
        end else if (RegWriteVW && (RA2VE == WA3W[VW-1:0])) begin
            fwdBV = 2'b01;
        end
    end

    // Stall terms: load currently in E, or a still-busy scoreboard entry.
    always_comb begin
        ldStallE = (MemtoRegE && ((RA1D == WA3E) || (RA2D == WA3E))) ||
                   (VLoadE && ((RA1VD == WA3E[VW-1:0]) || (RA2VD == WA3E[VW-1:0])));
        sbStall  = (sbS[RA1D] != '0) || (sbS[RA2D] != '0) ||
                   (sbV[RA1VD] != '0) || (sbV[RA2VD] != '0);
        ldStall  = ldStallE | sbStall;
        pcWrPend = PCSrcD | PCSrcE | PCSrcM;
    end

    // Output drive; reset forces every control and select low immediately.
    always_comb begin
        ForwardAE  = 2'b00;
        ForwardBE  = 2'b00;
        ForwardAVE = 2'b00;
        ForwardBVE = 2'b00;
        StallF     = 1'b0;
        StallD     = 1'b0;
        FlushE     = 1'b0;
        FlushD     = 1'b0;
        if (rst_n) begin
            ForwardAE  = fwdA;
            ForwardBE  = fwdB;
            ForwardAVE = fwdAV;
            ForwardBVE = fwdBV;
            StallF     = ldStall | pcWrPend;
            StallD     = ldStall & ~BranchTakenE;
            FlushE     = ldStall | BranchTakenE;
            FlushD     = pcWrPend | PCSrcW | BranchTakenE;
        end
    end

`ifdef HAZARD_PERF_EN
    // Saturating cycle counters of StallD and FlushD activity.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            StallCnt <= '0;
            FlushCnt <= '0;
        end else begin
            if (StallD && (StallCnt != '1)) begin
                StallCnt <= StallCnt + 32'd1;
            end
            if (FlushD && (FlushCnt != '1)) begin
                FlushCnt <= FlushCnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// tb_hazard_scoreboard_unit
//   Directed scenarios plus randomized traffic against a reference model that
//   tracks, per register, the cycle at which a pending load becomes forwardable.
//   Define HAZARD_PERF_EN here as well to check the perf counters.
module tb_hazard_scoreboard_unit;

    localparam int LDL = 3;
    localparam int PCR = 15;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] RA1D, RA2D, RA1VD, RA2VD, RA1E, RA2E, RA1VE, RA2VE;
    logic [3:0] WA3E, WA3M, WA3W;
    logic       RegWriteM, RegWriteW, RegWriteVM, RegWriteVW;
    logic       MemtoRegE, VLoadE;
    logic       PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE;
    logic [1:0] ForwardAE, ForwardBE, ForwardAVE, ForwardBVE;
    logic       StallF, StallD, FlushE, FlushD;
`ifdef HAZARD_PERF_EN
    logic [31:0] StallCnt, FlushCnt;
    logic [31:0] expStallCnt, expFlushCnt;
`endif

    int now;
    int busyS [16];
    int busyV [16];
    int checkCount;
    int passCount;
    bit lastStallD;
    bit lastFlushD;

    hazard_scoreboard_unit #(
        .NREG  (16),
        .NVREG (16),
        .LD_LAT(LDL),
        .PC_REG(PCR)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .RA1D(RA1D), .RA2D(RA2D), .RA1VD(RA1VD), .RA2VD(RA2VD),
        .RA1E(RA1E), .RA2E(RA2E), .RA1VE(RA1VE), .RA2VE(RA2VE),
        .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W),
        .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .RegWriteVM(RegWriteVM), .RegWriteVW(RegWriteVW),
        .MemtoRegE(MemtoRegE), .VLoadE(VLoadE),
        .PCSrcD(PCSrcD), .PCSrcE(PCSrcE), .PCSrcM(PCSrcM), .PCSrcW(PCSrcW),
        .BranchTakenE(BranchTakenE),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .ForwardAVE(ForwardAVE), .ForwardBVE(ForwardBVE),
        .StallF(StallF), .StallD(StallD), .FlushE(FlushE), .FlushD(FlushD)
`ifdef HAZARD_PERF_EN
        ,
        .StallCnt(StallCnt), .FlushCnt(FlushCnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got === exp) begin
            passCount++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, now);
        end
    endtask

    function automatic logic [1:0] expFwdS(input logic [3:0] ra);
        if (!rst_n || ra == 4'(PCR)) return 2'b00;
        if (RegWriteM && ra == WA3M) return 2'b10;
        if (RegWriteW && ra == WA3W) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [1:0] expFwdV(input logic [3:0] ra);
        if (!rst_n) return 2'b00;
        if (RegWriteVM && ra == WA3M) return 2'b10;
        if (RegWriteVW && ra == WA3W) return 2'b01;
        return 2'b00;
    endfunction

    // A register is busy until the cycle its load result reaches W.
    function automatic bit expLdStall();
        bit dep;
        bit busy;
        dep  = (MemtoRegE && (RA1D == WA3E || RA2D == WA3E)) ||
               (VLoadE && (RA1VD == WA3E || RA2VD == WA3E));
        busy = (now < busyS[RA1D]) || (now < busyS[RA2D]) ||
               (now < busyV[RA1VD]) || (now < busyV[RA2VD]);
        return dep || busy;
    endfunction

    task automatic compareModel();
        bit ld, pcw, eStallF, eStallD, eFlushE, eFlushD;
        ld      = expLdStall();
        pcw     = PCSrcD || PCSrcE || PCSrcM;
        eStallF = rst_n && (ld || pcw);
        eStallD = rst_n && ld && !BranchTakenE;
        eFlushE = rst_n && (ld || BranchTakenE);
        eFlushD = rst_n && (pcw || PCSrcW || BranchTakenE);
        checkEq("ForwardAE", ForwardAE, expFwdS(RA1E));
        checkEq("ForwardBE", ForwardBE, expFwdS(RA2E));
        checkEq("ForwardAVE", ForwardAVE, expFwdV(RA1VE));
        checkEq("ForwardBVE", ForwardBVE, expFwdV(RA2VE));
        checkEq("StallF", StallF, eStallF);
        checkEq("StallD", StallD, eStallD);
        checkEq("FlushE", FlushE, eFlushE);
        checkEq("FlushD", FlushD, eFlushD);
`ifdef HAZARD_PERF_EN
        checkEq("StallCnt", StallCnt, expStallCnt);
        checkEq("FlushCnt", FlushCnt, expFlushCnt);
`endif
        lastStallD = eStallD;
        lastFlushD = eFlushD;
    endtask

    task automatic updateModel();
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) begin
                busyS[i] = 0;
                busyV[i] = 0;
            end
`ifdef HAZARD_PERF_EN
            expStallCnt = 0;
            expFlushCnt = 0;
`endif
        end else begin
            if (!BranchTakenE && LDL > 1) begin
                if (MemtoRegE && WA3E != 4'(PCR)) busyS[WA3E] = now + LDL;
                if (VLoadE) busyV[WA3E] = now + LDL;
            end
`ifdef HAZARD_PERF_EN
            if (lastStallD && expStallCnt != 32'hFFFF_FFFF) expStallCnt++;
            if (lastFlushD && expFlushCnt != 32'hFFFF_FFFF) expFlushCnt++;
`endif
        end
        now++;
    endtask

    task automatic clearInputs();
        {RA1D, RA2D, RA1VD, RA2VD, RA1E, RA2E, RA1VE, RA2VE} = '0;
        {WA3E, WA3M, WA3W} = '0;
        {RegWriteM, RegWriteW, RegWriteVM, RegWriteVW, MemtoRegE, VLoadE} = '0;
        {PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE} = '0;
    endtask

    task automatic beginCycle();
        @(negedge clk);
        clearInputs();
    endtask

    task automatic settle();
        #1;
        compareModel();
    endtask

    task automatic endCycle();
        @(posedge clk);
        updateModel();
    endtask

    function automatic logic [3:0] pickReg();
        if ($urandom_range(0, 7) == 0) return 4'(PCR);
        return 4'($urandom_range(0, 3));
    endfunction

    initial begin
        now = 0;
        checkCount = 0;
        passCount = 0;
        lastStallD = 0;
        lastFlushD = 0;
        for (int i = 0; i < 16; i++) begin
            busyS[i] = 0;
            busyV[i] = 0;
        end
`ifdef HAZARD_PERF_EN
        expStallCnt = 0;
        expFlushCnt = 0;
`endif
        rst_n = 1'b0;
        clearInputs();

        // Reset state
        for (int k = 0; k < 2; k++) begin
            beginCycle();
            settle();
            checkEq("rst StallF", StallF, 1'b0);
            checkEq("rst FlushD", FlushD, 1'b0);
            endCycle();
        end

        // Forwarding priority M over W, then W only
        beginCycle();
        rst_n = 1'b1;
        RA1E = 4'd3; WA3M = 4'd3; RegWriteM = 1'b1; WA3W = 4'd3; RegWriteW = 1'b1;
        settle();
        checkEq("t1 fwdA M", ForwardAE, 2'b10);
        RegWriteM = 1'b0;
        settle();
        checkEq("t1 fwdA W", ForwardAE, 2'b01);
        endCycle();

        // PC index never forwarded
        beginCycle();
        RA2E = 4'd15; WA3M = 4'd15; RegWriteM = 1'b1;
        settle();
        checkEq("t2 fwdB pc", ForwardBE, 2'b00);
        endCycle();

        // Scalar load, dependent D op stalls for LD_LAT cycles
        beginCycle();
        MemtoRegE = 1'b1; WA3E = 4'd5; RA1D = 4'd5;
        settle();
        checkEq("t3 StallD e", StallD, 1'b1);
        endCycle();
        for (int k = 0; k < 3; k++) begin
            beginCycle();
            RA1D = 4'd5;
            settle();
            checkEq("t3 StallD sb", StallD, (k < 2) ? 1'b1 : 1'b0);
            checkEq("t3 StallF sb", StallF, (k < 2) ? 1'b1 : 1'b0);
            checkEq("t3 FlushE sb", FlushE, (k < 2) ? 1'b1 : 1'b0);
            endCycle();
        end

        // Branch taken squashes a vector load: flush, no scoreboard entry
        beginCycle();
        VLoadE = 1'b1; WA3E = 4'd2; RA2VD = 4'd2; BranchTakenE = 1'b1;
        settle();
        checkEq("t4 StallD", StallD, 1'b0);
        checkEq("t4 FlushD", FlushD, 1'b1);
        checkEq("t4 FlushE", FlushE, 1'b1);
        endCycle();
        beginCycle();
        RA2VD = 4'd2;
        settle();
        checkEq("t4 no sb", StallD, 1'b0);
        endCycle();

        // PC-write pending and PCSrcW-only
        beginCycle();
        PCSrcE = 1'b1;
        settle();
        checkEq("t5 StallF", StallF, 1'b1);
        checkEq("t5 FlushD", FlushD, 1'b1);
        checkEq("t5 StallD", StallD, 1'b0);
        endCycle();
        beginCycle();
        PCSrcW = 1'b1;
        settle();
        checkEq("t5 W FlushD", FlushD, 1'b1);
        checkEq("t5 W StallF", StallF, 1'b0);
        endCycle();

        // Asynchronous reset in the middle of a scoreboard stall
        beginCycle();
        MemtoRegE = 1'b1; WA3E = 4'd4;
        settle();
        endCycle();
        beginCycle();
        RA1D = 4'd4;
        settle();
        checkEq("t6 pre StallD", StallD, 1'b1);
        rst_n = 1'b0;
        #1;
        checkEq("t6 async StallD", StallD, 1'b0);
        checkEq("t6 async StallF", StallF, 1'b0);
        checkEq("t6 async FlushE", FlushE, 1'b0);
        checkEq("t6 async FlushD", FlushD, 1'b0);
        endCycle();
        beginCycle();
        rst_n = 1'b1;
        RA1D = 4'd4;
        settle();
        checkEq("t6 post StallD", StallD, 1'b0);
`ifdef HAZARD_PERF_EN
        checkEq("t6 StallCnt", StallCnt, 32'd0);
`endif
        endCycle();

        // Randomized traffic
        for (int n = 0; n < 800; n++) begin
            beginCycle();
            rst_n = ($urandom_range(0, 99) != 0);
            RA1D = pickReg(); RA2D = pickReg(); RA1VD = pickReg(); RA2VD = pickReg();
            RA1E = pickReg(); RA2E = pickReg(); RA1VE = pickReg(); RA2VE = pickReg();
            WA3E = pickReg(); WA3M = pickReg(); WA3W = pickReg();
            RegWriteM  = 1'($urandom_range(0, 1));
            RegWriteW  = 1'($urandom_range(0, 1));
            RegWriteVM = 1'($urandom_range(0, 1));
            RegWriteVW = 1'($urandom_range(0, 1));
            MemtoRegE  = ($urandom_range(0, 2) == 0);
            VLoadE     = ($urandom_range(0, 3) == 0);
            if (VLoadE && WA3E == 4'(PCR)) WA3E = 4'd3;
            PCSrcD = ($urandom_range(0, 11) == 0);
            PCSrcE = ($urandom_range(0, 11) == 0);
            PCSrcM = ($urandom_range(0, 11) == 0);
            PCSrcW = ($urandom_range(0, 11) == 0);
            BranchTakenE = ($urandom_range(0, 7) == 0);
            settle();
            endCycle();
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
